term_uart_tx: RTL and testbench

//  Transmit end of the terminal byte link: accepts the one-cycle byte strobes emitted by the

---
 rtl/term_pkg.sv | 28 ++
 rtl/term_fifo.sv | 67 ++++++
 rtl/term_uart_tx.sv | 157 +++++++++++++++
 tb/tb_term_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared definitions for the terminal byte link: UART timing default,
// transmit FSM state encoding and the ASCII command bytes that the
// terminal buffer also decodes.
package term_pkg;

  localparam int UART_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_FETCH = 3'd1,
    TX_LOAD  = 3'd2,
    TX_START = 3'd3,
    TX_DATA  = 3'd4,
    TX_STOP  = 3'd5
  } tx_state_e;

  localparam logic [7:0] ASCII_H     = 8'h68;
  localparam logic [7:0] ASCII_J     = 8'h6A;
  localparam logic [7:0] ASCII_K     = 8'h6B;
  localparam logic [7:0] ASCII_L     = 8'h6C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Width of a counter that holds 0..clks-1; never narrower than one bit.
  function automatic int baud_cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/term_fifo.sv
// Single-clock BRAM FIFO with a registered read port (one-cycle read
// latency). Occupancy is the difference of two AW+1-bit pointers, so full
// and empty are distinguished without a separate flag.
module term_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] rd_data_q;
  logic         do_rd, do_wr;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == LVL_MAX);
  assign empty_o   = (level_o == '0);
  assign rd_data_o = rd_data_q;

  // A pop frees a slot in the same cycle, so a write while full is still
  // accepted when it coincides with a read.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  // Next pointer values; both wrap naturally modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Registered read port; a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (rst)        rd_data_q <= '0;
    else if (do_rd) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/term_uart_tx.sv
// Transmit end of the terminal byte link: byte strobes go into a BRAM FIFO
// and are serialised as 8N1 UART on o_tx. The next byte is prefetched
// during the stop bit so back-to-back frames have no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to become non-empty (issues read)
// FETCH | waiting out the one-cycle BRAM read latency
// LOAD  | copy FIFO read data into the shift register
// START | start bit (line low)
// DATA  | data bits d0..d7, LSB first
// STOP  | stop bit (line high); prefetches the next byte on its first clock
module term_uart_tx
  import term_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DEPTH        = 1024,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   i_data,
  input  logic         i_data_v,
  output logic         o_tx,
  output logic         o_busy,
  output logic         o_overflow,
  output logic [AW:0]  o_level
);

  localparam int            CW        = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          pf_q, pf_d;
  logic          overflow_q, overflow_d;

  logic          fifo_rd;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          bit_end;

  term_fifo #(
    .W     (8),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (i_data_v),
    .wr_data_i (i_data),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .level_o   (o_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!fifo_empty) state_d = TX_FETCH;
      TX_FETCH: state_d = TX_LOAD;
      TX_LOAD:  state_d = TX_START;
      TX_START: if (bit_end) state_d = TX_DATA;
      TX_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = TX_STOP;
      TX_STOP:  if (bit_end) state_d = pf_q ? TX_START : TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // FSM outputs: FIFO read requests and the line level.
  always_comb begin
    fifo_rd = 1'b0;
    o_tx    = 1'b1;
    case (state_q)
      TX_IDLE:  fifo_rd = !fifo_empty;
      TX_START: o_tx = 1'b0;
      TX_DATA:  o_tx = shift_q[0];
      TX_STOP:  fifo_rd = (baud_q == '0) && !fifo_empty;
      default:  ;
    endcase
  end

  assign o_busy     = (state_q != TX_IDLE) || !fifo_empty;
  assign o_overflow = overflow_q;

  // Datapath next values: baud counter restarts at each bit boundary and
  // holds at zero outside a frame; the shift register reloads either in
  // LOAD or straight from the prefetched word at the end of the stop bit.
  always_comb begin
    baud_d     = '0;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pf_d       = pf_q;
    overflow_d = overflow_q | (i_data_v & fifo_full & ~fifo_rd);
    case (state_q)
      TX_LOAD: begin
        shift_d = fifo_rdata;
        bit_d   = '0;
        pf_d    = 1'b0;
      end
      TX_START: begin
        baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
      end
      TX_DATA: begin
        baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      TX_STOP: begin
        baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
        if (fifo_rd) pf_d = 1'b1;
        if (bit_end) begin
          pf_d = 1'b0;
          if (pf_q) begin
            shift_d = fifo_rdata;
            bit_d   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pf_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pf_q       <= pf_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_term_uart_tx.sv
// Bench for term_uart_tx: a deep instance (DEPTH=1024) for frame shape,
// refresh bursts and random traffic, and a shallow one (DEPTH=4) for the
// overflow and reset corner cases. Both use 4 clocks per bit.
module tb_term_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, v_a, tx_a, busy_a, ovf_a;
  logic [7:0]  data_a;
  logic [10:0] level_a;
  logic        rst_b, v_b, tx_b, busy_b, ovf_b;
  logic [7:0]  data_b;
  logic [2:0]  level_b;

  term_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(1024), .AW(10)) dut_a (
    .clk(clk), .rst(rst_a), .i_data(data_a), .i_data_v(v_a),
    .o_tx(tx_a), .o_busy(busy_a), .o_overflow(ovf_a), .o_level(level_a));

  term_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(4), .AW(2)) dut_b (
    .clk(clk), .rst(rst_b), .i_data(data_b), .i_data_v(v_b),
    .o_tx(tx_b), .o_busy(busy_b), .o_overflow(ovf_b), .o_level(level_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic bit check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line level per bit time: [0]=start .. [9]=stop
  } vec_t;

  exp_t       exp_a [$];
  logic [7:0] exp_b [$];
  int         sp = -100000;  // predicted start edge of the last frame on dut_a

  // Edge counter and reset seen by each DUT at that edge.
  logic mon_rst [2] = '{1'b1, 1'b1};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mon_rst[0] <= rst_a;
    mon_rst[1] <= rst_b;
  end

  int peak = 0;
  always @(negedge clk) if (int'(level_a) > peak) peak = int'(level_a);

  // Reference for a completed frame: bytes leave in strobe order; a byte
  // present before the first stop clock of the previous frame follows it
  // with no gap, otherwise the frame starts 3 edges after the later of its
  // arrival and the end of the previous frame.
  function automatic void frame_done(input int k, input logic [7:0] b, input int st);
    exp_t e;
    int   ps;
    if (k == 0) begin
      if (check("dut_a frame expected", exp_a.size() > 0, 1)) begin
        e = exp_a.pop_front();
        if (e.at <= sp + 9 * CPB) ps = sp + 10 * CPB;
        else ps = ((e.at > sp + 10 * CPB) ? e.at : sp + 10 * CPB) + 3;
        sp = ps;
        void'(check("dut_a frame data", b, e.data));
        void'(check("dut_a frame start", st, ps));
      end
    end else begin
      if (check("dut_b frame expected", exp_b.size() > 0, 1))
        void'(check("dut_b frame data", b, exp_b.pop_front()));
    end
  endfunction

  // Line decoder: validates bit widths and levels, rebuilds each byte.
  int         pos [2] = '{-1, -1};
  logic [7:0] fb [2];
  int         fst [2];
  always @(negedge clk) begin
    logic t;
    int   idx;
    for (int k = 0; k < 2; k++) begin
      t = (k == 0) ? tx_a : tx_b;
      if (mon_rst[k]) begin
        pos[k] = -1;
      end else if (pos[k] < 0) begin
        if (t == 1'b0) begin
          pos[k] = 1;
          fst[k] = cyc;
        end
      end else begin
        idx = pos[k] / CPB;
        if (idx == 0) begin
          if (!check($sformatf("dut%0d start bit level", k), t, 0)) pos[k] = -2;
        end else if (idx == 9) begin
          if (!check($sformatf("dut%0d stop bit level", k), t, 1)) pos[k] = -2;
        end else if (pos[k] % CPB == 0) begin
          fb[k][idx-1] = t;
        end else begin
          if (!check($sformatf("dut%0d data bit hold", k), t, fb[k][idx-1])) pos[k] = -2;
        end
        if (pos[k] == -2) pos[k] = -1;
        else begin
          pos[k]++;
          if (pos[k] == 10 * CPB) begin
            pos[k] = -1;
            frame_done(k, fb[k], fst[k]);
          end
        end
      end
    end
  end

  task automatic send_a(input logic [7:0] d);
    exp_t e;
    data_a = d;
    v_a    = 1'b1;
    @(negedge clk);
    v_a    = 1'b0;
    e.data = d;
    e.at   = cyc;
    exp_a.push_back(e);
  endtask

  task automatic send_b(input logic [7:0] d);
    data_b = d;
    v_b    = 1'b1;
    @(negedge clk);
    v_b    = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget, input string name);
    for (int i = 0; i < budget && ((k == 0) ? busy_a : busy_b); i++) @(negedge clk);
    void'(check(name, (k == 0) ? busy_a : busy_b, 0));
  endtask

  task automatic watch_line_b(input int n, input string name);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_b !== 1'b1) lows++;
    end
    void'(check(name, lows, 0));
  endtask

  vec_t       vecs [5];
  logic [9:0] frm;
  logic [7:0] fill [5];
  int         n;

  initial begin
    vecs[0] = '{8'h41, 10'b1010000010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h80, 10'b1100000000};

    rst_a = 1'b1; rst_b = 1'b1;
    v_a = 1'b0; v_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    repeat (3) @(negedge clk);
    void'(check("reset tx_a", tx_a, 1));
    void'(check("reset busy_a", busy_a, 0));
    void'(check("reset ovf_a", ovf_a, 0));
    void'(check("reset level_a", level_a, 0));
    void'(check("reset tx_b", tx_b, 1));
    void'(check("reset busy_b", busy_b, 0));
    void'(check("reset ovf_b", ovf_b, 0));
    void'(check("reset level_b", level_b, 0));
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // Single bytes into an idle block: exact waveform and latency.
    for (int v = 0; v < 5; v++) begin
      frm = vecs[v].frame;
      send_a(vecs[v].data);
      void'(check($sformatf("vec%0d level after strobe", v), level_a, 1));
      void'(check($sformatf("vec%0d busy after strobe", v), busy_a, 1));
      void'(check($sformatf("vec%0d tx before start", v), tx_a, 1));
      repeat (3) @(negedge clk);
      for (int i = 0; i < 10 * CPB; i++) begin
        void'(check($sformatf("vec%0d tx clk%0d", v, i), tx_a, frm[i / CPB]));
        if (i == 10 * CPB - 1) void'(check($sformatf("vec%0d busy in stop", v), busy_a, 1));
        @(negedge clk);
      end
      void'(check($sformatf("vec%0d busy after stop", v), busy_a, 0));
      void'(check($sformatf("vec%0d level after frame", v), level_a, 0));
      repeat (2) @(negedge clk);
    end

    // Refresh burst: 1024 bytes, one every 3 clocks.
    peak = 0;
    for (int i = 0; i < 1024; i++) begin
      send_a(8'(i));
      repeat (2) @(negedge clk);
    end
    wait_idle(0, 1024 * 10 * CPB + 200, "burst drain");
    void'(check("burst overflow", ovf_a, 0));
    void'(check("burst peak within depth", peak <= 1024, 1));
    void'(check("burst queue built up", peak > 512, 1));
    void'(check("burst all frames seen", exp_a.size(), 0));

    // Random bytes with random gaps: idle starts, late arrivals, prefetches.
    for (int i = 0; i < 80; i++) begin
      send_a(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    wait_idle(0, 80 * 10 * CPB + 200, "random drain");
    void'(check("random all frames seen", exp_a.size(), 0));
    void'(check("random overflow", ovf_a, 0));

    // Overflow on the shallow FIFO while a frame is on the line.
    send_b(8'h11);
    exp_b.push_back(8'h11);
    for (int j = 0; j < 4; j++) begin
      send_b(8'h22 + 8'(j * 17));
      exp_b.push_back(8'h22 + 8'(j * 17));
    end
    void'(check("ovf level full", level_b, 4));
    void'(check("ovf flag before extra", ovf_b, 0));
    send_b(8'h66);
    void'(check("ovf level after extra", level_b, 4));
    void'(check("ovf flag set", ovf_b, 1));
    wait_idle(1, 6 * 10 * CPB + 100, "ovf drain");
    void'(check("ovf flag sticky", ovf_b, 1));
    void'(check("ovf frames seen", exp_b.size(), 0));
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    void'(check("ovf cleared by rst", ovf_b, 0));
    repeat (2) @(negedge clk);

    // Full FIFO with a strobe on the same edge as the IDLE->FETCH pop.
    fill = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    send_b(8'h10);
    exp_b.push_back(8'h10);
    repeat (10 * CPB - 1) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      data_b = fill[j];
      v_b    = 1'b1;
      @(negedge clk);
      exp_b.push_back(fill[j]);
      if (j == 3) void'(check("pop+wr full before", level_b, 4));
    end
    v_b = 1'b0;
    void'(check("pop+wr level", level_b, 4));
    void'(check("pop+wr no overflow", ovf_b, 0));
    wait_idle(1, 6 * 10 * CPB + 100, "pop+wr drain");
    void'(check("pop+wr frames seen", exp_b.size(), 0));
    void'(check("pop+wr overflow end", ovf_b, 0));
    repeat (2) @(negedge clk);

    // Reset during data bit 3 with two bytes queued.
    send_b(8'hA5);
    send_b(8'h01);
    send_b(8'h02);
    void'(check("abort queued", level_b, 2));
    repeat (18) @(negedge clk);
    void'(check("abort in bit3", tx_b, 0));
    rst_b = 1'b1;
    @(negedge clk);
    void'(check("abort tx high", tx_b, 1));
    void'(check("abort level", level_b, 0));
    void'(check("abort busy", busy_b, 0));
    rst_b = 1'b0;
    watch_line_b(100, "abort line stays idle");
    void'(check("abort busy later", busy_b, 0));

    // Strobe during reset is ignored.
    rst_b  = 1'b1;
    data_b = 8'h77;
    v_b    = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    v_b   = 1'b0;
    void'(check("rst strobe level", level_b, 0));
    void'(check("rst strobe busy", busy_b, 0));
    watch_line_b(50, "rst strobe line idle");
    void'(check("rst strobe level later", level_b, 0));

    void'(check("dut_a no pending frames", exp_a.size(), 0));
    void'(check("dut_b no pending frames", exp_b.size(), 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so a stuck run still reports.
  initial begin
    n = 0;
    while (n < 90000) begin
      @(negedge clk);
      n++;
    end
    void'(check("global cycle budget", n, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "cycle budget exhausted");
  end

endmodule
